// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the shift sequencer: FSM state encoding and
// the bit-count clamp used when a job is accepted.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // A count of zero, or one larger than the register, means "the whole word".
    function automatic int unsigned clamp_count(input int unsigned cnt, input int unsigned width);
        if (cnt == 0 || cnt > width) begin
            return width;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/shift_seq_reg.sv
// Parallel-load bidirectional shift register owned by the shift sequencer.
// Load has priority over shift; the asynchronous clear returns it to zero.
module shift_seq_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             shift,
    input  logic             left,
    input  logic [WIDTH-1:0] din,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            if (left) begin
                q <= {q[WIDTH-2:0], ser_in};
            end else begin
                q <= {ser_in, q[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Shift sequencer: accepts a word and bit count, shifts the bits out serially
// while capturing ser_in, then hands back the result. Optional stall input is
// enabled by defining SHIFT_SEQ_STALL_EN.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             left,
    input  logic [CNT_W-1:0] count,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_en,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] dout,
    output logic             busy
`ifdef SHIFT_SEQ_STALL_EN
    ,
    input  logic             stall
`endif
);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] bit_cnt;
    logic             dir;
    logic [WIDTH-1:0] q;
    logic             accept;
    logic             advance;

    assign accept = (state == IDLE) && start_valid;

`ifdef SHIFT_SEQ_STALL_EN
    assign advance = (state == SHIFT) && !stall;
`else
    assign advance = (state == SHIFT);
`endif

    shift_seq_reg #(
        .WIDTH(WIDTH)
    ) u_reg (
        .clock  (clock),
        .reset_n(reset_n),
        .load   (accept),
        .shift  (advance),
        .left   (dir),
        .din    (din),
        .ser_in (ser_in),
        .q      (q)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Direction and remaining-bit counter are latched only on the accept edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= '0;
            dir     <= 1'b0;
        end else if (accept) begin
            bit_cnt <= CNT_W'(clamp_count(32'(count), WIDTH));
            dir     <= left;
        end else if (advance) begin
            bit_cnt <= bit_cnt - CNT_W'(1);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_valid) next_state = SHIFT;
            SHIFT:   if (advance && bit_cnt == CNT_W'(1)) next_state = DONE;
            DONE:    if (done_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        start_ready = 1'b0;
        ser_en      = 1'b0;
        ser_out     = 1'b0;
        done_valid  = 1'b0;
        busy        = 1'b0;
        case (state)
            IDLE: start_ready = 1'b1;
            SHIFT: begin
                ser_en  = advance;
                ser_out = dir ? q[WIDTH-1] : q[0];
                busy    = 1'b1;
            end
            DONE: begin
                done_valid = 1'b1;
                busy       = 1'b1;
            end
            default: start_ready = 1'b0;
        endcase
    end

    assign dout = q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: a job-level model predicts every
// output each cycle, plus literal checks on the reference jobs.
module tb_shift_sequencer;

    localparam int W     = 8;
    localparam int CNT_W = $clog2(W + 1);

    logic             clock = 1'b0;
    logic             reset_n;
    logic             start_valid;
    logic             start_ready;
    logic [W-1:0]     din;
    logic             left;
    logic [CNT_W-1:0] count;
    logic             ser_in;
    logic             ser_out;
    logic             ser_en;
    logic             done_valid;
    logic             done_ready;
    logic [W-1:0]     dout;
    logic             busy;
`ifdef SHIFT_SEQ_STALL_EN
    logic             stall;
`endif

    shift_sequencer #(
        .WIDTH(W),
        .CNT_W(CNT_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .din        (din),
        .left       (left),
        .count      (count),
        .ser_in     (ser_in),
        .ser_out    (ser_out),
        .ser_en     (ser_en),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .dout       (dout),
        .busy       (busy)
`ifdef SHIFT_SEQ_STALL_EN
        ,
        .stall      (stall)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tests  = 0;
    int errors = 0;

    bit         check_en = 1'b0;
    bit         e_start_ready, e_busy, e_ser_en, e_ser_out, e_done_valid;
    logic [W-1:0] e_dout;
    logic [W-1:0] last_word = '0;

    logic [15:0]  obs_bits;
    int           obs_pulses;
    bit           done_seen;
    int           done_cyc;
    logic [W-1:0] obs_dout;
    int           accept_cyc;
    bit           job_reset;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Word after k shifts: ins[i] is the i-th bit captured from ser_in.
    function automatic logic [W-1:0] model_word(input logic [W-1:0] d, input bit lft,
                                                input logic [W-1:0] ins, input int k);
        logic [W-1:0] w;
        w = d;
        for (int i = 0; i < k; i++) begin
            if (lft) w = (w << 1) | W'(ins[i]);
            else     w = (w >> 1) | (W'(ins[i]) << (W - 1));
        end
        return w;
    endfunction

    // Expected serial stream, first bit out in the highest used position.
    function automatic logic [15:0] model_stream(input logic [W-1:0] d, input bit lft, input int n);
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < n; i++) begin
            s = {s[14:0], (lft ? d[W-1-i] : d[i])};
        end
        return s;
    endfunction

    task automatic set_exp_idle(input logic [W-1:0] word);
        e_start_ready = 1'b1;
        e_busy        = 1'b0;
        e_ser_en      = 1'b0;
        e_ser_out     = 1'b0;
        e_done_valid  = 1'b0;
        e_dout        = word;
    endtask

    task automatic compare_cycle();
        check("start_ready", 32'(start_ready), 32'(e_start_ready));
        check("busy",        32'(busy),        32'(e_busy));
        check("ser_en",      32'(ser_en),      32'(e_ser_en));
        check("ser_out",     32'(ser_out),     32'(e_ser_out));
        check("done_valid",  32'(done_valid),  32'(e_done_valid));
        check("dout",        32'(dout),        32'(e_dout));
        if (start_valid && start_ready) begin
            obs_bits   = '0;
            obs_pulses = 0;
            done_seen  = 1'b0;
            done_cyc   = -1;
        end
        if (ser_en) begin
            obs_bits = {obs_bits[14:0], ser_out};
            obs_pulses++;
        end
        if (done_valid && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
            obs_dout  = dout;
        end
    endtask

    // stall_at: >=0 directed stall window, -1 random stalls, -2 none.
    // rst_at: shift index at which reset is pulsed, -1 for none.
    task automatic run_job(input logic [W-1:0] d, input bit lft, input logic [CNT_W-1:0] cnt,
                           input int ser_mode, input int rdy_delay, input int stall_at,
                           input int stall_len, input int rst_at);
        logic [W-1:0] ins;
        logic [W-1:0] fin;
        int n, k, nstall, scnt;
        bit stl;
        ins = '0; k = 0; nstall = 0; scnt = 0;
        job_reset = 1'b0;
        n = (cnt == 0 || int'(cnt) > W) ? W : int'(cnt);

        start_valid = 1'b1; din = d; left = lft; count = cnt;
        set_exp_idle(last_word);
        @(posedge clock); #1;
        accept_cyc  = cyc;
        start_valid = 1'b0;
        din   = W'($urandom);
        left  = 1'($urandom);
        count = CNT_W'($urandom);

        while (k < n) begin
            if (k == rst_at) begin
                reset_n = 1'b0;
                start_valid = 1'b0;
                last_word = '0;
                set_exp_idle('0);
                @(posedge clock); #1;
                reset_n = 1'b1;
                set_exp_idle('0);
                job_reset = 1'b1;
                return;
            end
`ifdef SHIFT_SEQ_STALL_EN
            if (stall_at == -1) stl = ($urandom_range(0, 3) == 0);
            else                stl = (k == stall_at && scnt < stall_len);
            stall = stl;
`else
            stl = 1'b0;
`endif
            if (stl) begin scnt++; nstall++; end
            ser_in      = (ser_mode == 0) ? 1'b0 : (ser_mode == 1) ? 1'b1 : 1'($urandom);
            start_valid = 1'($urandom);
            done_ready  = 1'($urandom);
            e_start_ready = 1'b0;
            e_busy        = 1'b1;
            e_ser_en      = !stl;
            e_ser_out     = lft ? d[W-1-k] : d[k];
            e_done_valid  = 1'b0;
            e_dout        = model_word(d, lft, ins, k);
            @(posedge clock); #1;
            if (!stl) begin
                ins[k] = ser_in;
                k++;
            end
        end

        fin = model_word(d, lft, ins, n);
        last_word = fin;
        for (int j = 0; j <= rdy_delay; j++) begin
            e_start_ready = 1'b0;
            e_busy        = 1'b1;
            e_ser_en      = 1'b0;
            e_ser_out     = 1'b0;
            e_done_valid  = 1'b1;
            e_dout        = fin;
            done_ready    = (j == rdy_delay);
            start_valid   = 1'($urandom);
`ifdef SHIFT_SEQ_STALL_EN
            stall = 1'($urandom);
`endif
            @(posedge clock); #1;
        end
        done_ready  = 1'b0;
        start_valid = 1'b0;
`ifdef SHIFT_SEQ_STALL_EN
        stall = 1'b0;
`endif
        set_exp_idle(fin);

        check("pulses",  32'(obs_pulses), 32'(n));
        check("stream",  32'(obs_bits), 32'(model_stream(d, lft, n)));
        check("latency", 32'(done_cyc - accept_cyc + 1), 32'(n + nstall + 1));
        check("result",  32'(obs_dout), 32'(fin));
    endtask

    initial begin
        reset_n = 1'b0; start_valid = 1'b0; din = '0; left = 1'b0; count = '0;
        ser_in = 1'b0; done_ready = 1'b0;
`ifdef SHIFT_SEQ_STALL_EN
        stall = 1'b0;
`endif
        obs_bits = '0; obs_pulses = 0; done_seen = 1'b0; done_cyc = -1; obs_dout = '0;
        accept_cyc = 0; job_reset = 1'b0;
        set_exp_idle('0);
        check_en = 1'b1;

        fork
            forever begin
                @(negedge clock);
                if (check_en) compare_cycle();
            end
        join_none

        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;

        // Reference job: A5 left, full word, zeros in.
        run_job(8'hA5, 1'b1, 4'd0, 0, 0, -2, 0, -1);
        check("A5L_stream",  32'(obs_bits[7:0]), 32'h0000_00A5);
        check("A5L_dout",    32'(obs_dout), 32'h0000_0000);
        check("A5L_latency", 32'(done_cyc - accept_cyc + 1), 32'd9);

        // Reference job: A5 right, 3 bits, ones in.
        run_job(8'hA5, 1'b0, 4'd3, 1, 0, -2, 0, -1);
        check("A5R_stream",  32'(obs_bits[2:0]), 32'h0000_0005);
        check("A5R_dout",    32'(obs_dout), 32'h0000_00F4);
        check("A5R_latency", 32'(done_cyc - accept_cyc + 1), 32'd4);

        // Backpressure: result held for five cycles before it is taken.
        run_job(8'h3C, 1'b1, 4'd5, 2, 5, -2, 0, -1);

        // Oversized count clamps to the full word.
        run_job(8'h5A, 1'b0, 4'd12, 2, 1, -2, 0, -1);
        check("clamp_pulses", 32'(obs_pulses), 32'd8);

        // Reset in the middle of a job discards it.
        run_job(8'hFF, 1'b1, 4'd6, 2, 0, -2, 0, 3);
        check("rst_discard", 32'(job_reset), 32'd1);

`ifdef SHIFT_SEQ_STALL_EN
        run_job(8'hA5, 1'b1, 4'd4, 0, 0, 2, 2, -1);
        check("stall_stream",  32'(obs_bits[3:0]), 32'h0000_000A);
        check("stall_latency", 32'(done_cyc - accept_cyc + 1), 32'd7);
`endif

        for (int i = 0; i < 40; i++) begin
            run_job(W'($urandom), 1'($urandom), CNT_W'($urandom_range(0, 15)), 2,
                    int'($urandom_range(0, 3)), -1, 0, -1);
        end

        repeat (2) @(posedge clock);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
